// File: rtl/ps2_c64_pkg.sv
// ps2_c64_pkg
//   Shared definitions for the PS/2 to C64 keyboard matrix bridge:
//   prefix scancodes, the receive FSM state encoding and the matrix
//   index helper used by the top and the keymap consumers.
package ps2_c64_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // PS/2 receive FSM: IDLE waits for a start bit, DATA shifts eight
    // bits LSB first, PARITY captures the odd-parity bit, STOP checks
    // the stop bit and decides whether the byte is accepted.
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Matrix bit position of key (row, col): row*8 + col.
    function automatic logic [5:0] idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/ps2_c64_keymap.sv
// ps2_c64_keymap
//   Combinational scancode lookup: {ext, code} -> C64 matrix position.
//   Ports:
//     ext        in   1  E0 prefix was seen before this code
//     code       in   8  set-2 scancode (make form)
//     valid      out  1  code maps to a C64 key (matrix key or RESTORE)
//     row        out  3  C64 matrix row (CIA1 port A bit)
//     col        out  3  C64 matrix column (CIA1 port B bit)
//     is_restore out  1  code is the RESTORE key (outside the matrix)
//   Table entries are written as 6'o<row><col>.
module ps2_c64_keymap (
    input  logic       ext,
    input  logic [7:0] code,
    output logic       valid,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       is_restore
);

    logic [5:0] rc;

    always_comb begin
        valid      = 1'b1;
        rc         = 6'o00;
        is_restore = 1'b0;
        case ({ext, code})
            // row 0
            9'h066: rc = 6'o00; // Backspace -> DEL
            9'h05A: rc = 6'o01; // Enter -> RETURN
            9'h15A: rc = 6'o01; // keypad Enter -> RETURN
            9'h174: rc = 6'o02; // Right arrow -> CRSR RIGHT
            9'h083: rc = 6'o03; // F7
            9'h005: rc = 6'o04; // F1
            9'h004: rc = 6'o05; // F3
            9'h003: rc = 6'o06; // F5
            9'h172: rc = 6'o07; // Down arrow -> CRSR DOWN
            // row 1
            9'h026: rc = 6'o10; // 3
            9'h01D: rc = 6'o11; // W
            9'h01C: rc = 6'o12; // A
            9'h025: rc = 6'o13; // 4
            9'h01A: rc = 6'o14; // Z
            9'h01B: rc = 6'o15; // S
            9'h024: rc = 6'o16; // E
            9'h012: rc = 6'o17; // Left Shift
            // row 2
            9'h02E: rc = 6'o20; // 5
            9'h02D: rc = 6'o21; // R
            9'h023: rc = 6'o22; // D
            9'h036: rc = 6'o23; // 6
            9'h021: rc = 6'o24; // C
            9'h02B: rc = 6'o25; // F
            9'h02C: rc = 6'o26; // T
            9'h022: rc = 6'o27; // X
            // row 3
            9'h03D: rc = 6'o30; // 7
            9'h035: rc = 6'o31; // Y
            9'h034: rc = 6'o32; // G
            9'h03E: rc = 6'o33; // 8
            9'h032: rc = 6'o34; // B
            9'h033: rc = 6'o35; // H
            9'h03C: rc = 6'o36; // U
            9'h02A: rc = 6'o37; // V
            // row 4
            9'h046: rc = 6'o40; // 9
            9'h043: rc = 6'o41; // I
            9'h03B: rc = 6'o42; // J
            9'h045: rc = 6'o43; // 0
            9'h03A: rc = 6'o44; // M
            9'h042: rc = 6'o45; // K
            9'h044: rc = 6'o46; // O
            9'h031: rc = 6'o47; // N
            // row 5
            9'h079: rc = 6'o50; // keypad + -> +
            9'h04D: rc = 6'o51; // P
            9'h04B: rc = 6'o52; // L
            9'h04E: rc = 6'o53; // - -> -
            9'h049: rc = 6'o54; // . -> .
            9'h052: rc = 6'o55; // ' -> :
            9'h054: rc = 6'o56; // [ -> @
            9'h041: rc = 6'o57; // , -> ,
            // row 6
            9'h05D: rc = 6'o60; // \ -> pound
            9'h05B: rc = 6'o61; // ] -> *
            9'h04C: rc = 6'o62; // ; -> ;
            9'h16C: rc = 6'o63; // Home -> CLR/HOME
            9'h059: rc = 6'o64; // Right Shift
            9'h055: rc = 6'o65; // = -> =
            9'h171: rc = 6'o66; // Delete -> up-arrow
            9'h04A: rc = 6'o67; // / -> /
            // row 7
            9'h016: rc = 6'o70; // 1
            9'h00E: rc = 6'o71; // ` -> left-arrow
            9'h00D: rc = 6'o72; // Tab -> CTRL
            9'h01E: rc = 6'o73; // 2
            9'h029: rc = 6'o74; // Space
            9'h014: rc = 6'o75; // Left Ctrl -> C=
            9'h015: rc = 6'o76; // Q
            9'h076: rc = 6'o77; // Esc -> RUN/STOP
            // RESTORE sits outside the matrix
            9'h17D: is_restore = 1'b1; // PgUp
            default: valid = 1'b0;
        endcase
    end

    assign row = rc[5:3];
    assign col = rc[2:0];

endmodule

// File: rtl/ps2_c64_keyboard.sv
// ps2_c64_keyboard
//   Receives PS/2 set-2 scancodes, keeps a 64-key C64 matrix image and
//   answers CIA1 row scans with active-low column sense. RESTORE is kept
//   as a separate level.
//   Parameters:
//     TIMEOUT_CYCLES  dot_clk cycles without a PS/2 falling edge before a
//                     partial frame is dropped
//     SYNC_STAGES     synchroniser depth for ps2_clk/ps2_data (>= 2)
//   Ports:
//     dot_clk      in   1  system clock
//     reset        in   1  synchronous, active-high
//     ps2_clk      in   1  asynchronous PS/2 clock (never driven)
//     ps2_data     in   1  asynchronous PS/2 data (never driven)
//     keyboard_ROW in   8  row select, bit r low selects row r
//     keyboard_COL out  8  column sense, bit c low if a selected row has (r,c) down
//     restore      out  1  high while RESTORE is held
//     key_event    out  1  one-cycle pulse per accepted mapped make/break
//   Handshake note: the receiver hands bytes to the decoder with a
//   one-cycle rx_valid strobe and no back-pressure; the decoder always
//   consumes a byte in the cycle rx_valid is high.
module ps2_c64_keyboard
    import ps2_c64_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       dot_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] keyboard_ROW,
    output logic [7:0] keyboard_COL,
    output logic       restore,
    output logic       key_event
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detect. Reset to 1 so an idle
    // (high) bus never looks like an edge after reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_cur;
    logic                   data_cur;
    logic                   fall;

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_cur;
        end
    end

    assign clk_cur  = clk_sync[SYNC_STAGES-1];
    assign data_cur = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_cur;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t         state_q;
    rx_state_t         state_d;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q;
    logic              par_q;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout_hit;
    logic              start_en;
    logic              shift_en;
    logic              par_en;
    logic              stop_en;
    logic              rx_valid;
    logic [7:0]        rx_byte;

    // A falling edge in the same cycle always wins over the timeout.
    assign timeout_hit = !fall && (state_q != RX_IDLE) &&
                         (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

    // state register
    always_ff @(posedge dot_clk) begin
        if (reset) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            case (state_q)
                RX_IDLE:   if (!data_cur) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    // FSM outputs: datapath enables for this cycle's falling edge
    always_comb begin
        start_en = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        if (fall) begin
            case (state_q)
                RX_IDLE:   start_en = !data_cur;
                RX_DATA:   shift_en = 1'b1;
                RX_PARITY: par_en   = 1'b1;
                RX_STOP:   stop_en  = 1'b1;
                default:   ;
            endcase
        end
    end

    // receive datapath
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            to_cnt   <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= 8'h00;
        end else begin
            if (start_en)      bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

            if (shift_en) shift_q <= {data_cur, shift_q[7:1]};
            if (par_en)   par_q   <= data_cur;

            if (fall || state_q == RX_IDLE) to_cnt <= '0;
            else                            to_cnt <= to_cnt + 1'b1;

            // Accept on a good stop bit with odd parity across data+parity.
            rx_valid <= stop_en && data_cur && (^{shift_q, par_q});
            if (stop_en) rx_byte <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Scancode decode and matrix update
    // ------------------------------------------------------------------
    logic        ext_q;
    logic        brk_q;
    logic [63:0] key_down;
    logic        km_valid;
    logic [2:0]  km_row;
    logic [2:0]  km_col;
    logic        km_is_restore;

    ps2_c64_keymap u_keymap (
        .ext        (ext_q),
        .code       (rx_byte),
        .valid      (km_valid),
        .row        (km_row),
        .col        (km_col),
        .is_restore (km_is_restore)
    );

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            key_down  <= 64'd0;
            restore   <= 1'b0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    // Any non-prefix byte ends the sequence, mapped or not.
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (km_valid) begin
                        key_event <= 1'b1;
                        if (km_is_restore) restore <= ~brk_q;
                        else               key_down[idx(km_row, km_col)] <= ~brk_q;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Column sense: selected rows OR together, no ghosting model.
    // ------------------------------------------------------------------
    logic [7:0] col_next;

    always_comb begin
        col_next = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (key_down[idx(3'(r), 3'(c))] && !keyboard_ROW[r])
                    col_next[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge dot_clk) begin
        if (reset) keyboard_COL <= 8'hFF;
        else       keyboard_COL <= col_next;
    end

endmodule

// File: tb/tb_ps2_c64_keyboard.sv
// tb_ps2_c64_keyboard
//   Directed bench: a table of single-key vectors plus hand-written
//   sequences for latency, chords, bad frames, timeout, RESTORE and reset.
module tb_ps2_c64_keyboard;

    localparam int TO   = 16384;
    localparam int HALF = 8;

    logic       dot_clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keyboard_ROW;
    logic [7:0] keyboard_COL;
    logic       restore;
    logic       key_event;

    int tests;
    int fails;
    int ev_cnt;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       ext;
        logic [7:0] code;
        logic [7:0] row_sel;
        logic [7:0] exp_col;
    } vec_t;

    vec_t vecs[12];

    ps2_c64_keyboard #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .dot_clk      (dot_clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keyboard_ROW (keyboard_ROW),
        .keyboard_COL (keyboard_COL),
        .restore      (restore),
        .key_event    (key_event)
    );

    // ---------------- clock / reset ----------------
    initial dot_clk = 1'b0;
    always #5 dot_clk = ~dot_clk;

    always @(negedge dot_clk) if (key_event === 1'b1) ev_cnt++;

    task automatic do_reset();
        @(negedge dot_clk);
        reset = 1'b1;
        @(negedge dot_clk);
        reset = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic ps2_bit(input logic b);
        @(negedge dot_clk);
        ps2_data = b;
        repeat (HALF) @(negedge dot_clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge dot_clk);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop).
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_v, input int nbits);
        logic [10:0] f;
        f = {stop_v, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge dot_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
    endtask

    task automatic press(input logic ext, input logic [7:0] code);
        if (ext) send_byte(8'hE0);
        send_byte(code);
    endtask

    task automatic release_key(input logic ext, input logic [7:0] code);
        if (ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(code);
    endtask

    // Changes the row select and lets one active edge register the columns.
    task automatic set_row(input logic [7:0] r);
        @(negedge dot_clk);
        keyboard_ROW = r;
        @(negedge dot_clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ev0;
        logic [7:0] e;
        tests        = 0;
        fails        = 0;
        ev_cnt       = 0;
        reset        = 1'b1;
        ps2_clk      = 1'b1;
        ps2_data     = 1'b1;
        keyboard_ROW = 8'hFE;

        vecs[0]  = '{1'b0, 8'h1C, 8'hFD, 8'hFB}; // A       r1 c2
        vecs[1]  = '{1'b0, 8'h12, 8'hFD, 8'h7F}; // LShift  r1 c7
        vecs[2]  = '{1'b0, 8'h59, 8'hBF, 8'hEF}; // RShift  r6 c4
        vecs[3]  = '{1'b0, 8'h5A, 8'hFE, 8'hFD}; // Return  r0 c1
        vecs[4]  = '{1'b0, 8'h29, 8'h7F, 8'hEF}; // Space   r7 c4
        vecs[5]  = '{1'b0, 8'h76, 8'h7F, 8'h7F}; // RUN/STOP r7 c7
        vecs[6]  = '{1'b0, 8'h66, 8'hFE, 8'hFE}; // DEL     r0 c0
        vecs[7]  = '{1'b1, 8'h74, 8'hFE, 8'hFB}; // CRSR RT r0 c2
        vecs[8]  = '{1'b0, 8'h16, 8'h7F, 8'hFE}; // 1       r7 c0
        vecs[9]  = '{1'b0, 8'h15, 8'h7F, 8'hBF}; // Q       r7 c6
        vecs[10] = '{1'b0, 8'h45, 8'hEF, 8'hF7}; // 0       r4 c3
        vecs[11] = '{1'b0, 8'h1C, 8'hFE, 8'hFF}; // A, wrong row selected

        repeat (3) @(negedge dot_clk);
        do_reset();

        // Reset then idle
        check("reset_col", keyboard_COL, 8'hFF);
        check("reset_restore", restore, 1'b0);
        check("reset_event", key_event, 1'b0);

        // Frame 1C, then row 1 selected one cycle later
        ev0 = ev_cnt;
        press(1'b0, 8'h1C);
        check("a_make_event", ev_cnt - ev0, 1);
        check("a_row0_col", keyboard_COL, 8'hFF);
        @(negedge dot_clk);
        keyboard_ROW = 8'hFD;
        #1;
        check("a_lat_before", keyboard_COL, 8'hFF);
        @(negedge dot_clk);
        check("a_lat_after", keyboard_COL, 8'hFB);
        ev0 = ev_cnt;
        release_key(1'b0, 8'h1C);
        check("a_break_col", keyboard_COL, 8'hFF);
        check("a_break_event", ev_cnt - ev0, 1);

        // Single-key table
        foreach (vecs[i]) begin
            ev0 = ev_cnt;
            press(vecs[i].ext, vecs[i].code);
            set_row(vecs[i].row_sel);
            exp_q.push_back(vecs[i].exp_col);
            e = exp_q.pop_front();
            check($sformatf("tbl%0d_make_col", i), keyboard_COL, e);
            check($sformatf("tbl%0d_make_event", i), ev_cnt - ev0, 1);
            release_key(vecs[i].ext, vecs[i].code);
            check($sformatf("tbl%0d_break_col", i), keyboard_COL, 8'hFF);
        end

        // Chord across two rows
        press(1'b0, 8'h12);
        press(1'b0, 8'h29);
        set_row(8'h7D);
        check("chord_rows17", keyboard_COL, 8'h6F);
        set_row(8'hFD);
        check("chord_row1", keyboard_COL, 8'h7F);
        set_row(8'hFF);
        check("chord_no_row", keyboard_COL, 8'hFF);
        release_key(1'b0, 8'h12);
        release_key(1'b0, 8'h29);
        set_row(8'h7D);
        check("chord_released", keyboard_COL, 8'hFF);

        // Typematic repeat is idempotent
        ev0 = ev_cnt;
        press(1'b0, 8'h1C);
        press(1'b0, 8'h1C);
        set_row(8'hFD);
        check("repeat_col", keyboard_COL, 8'hFB);
        release_key(1'b0, 8'h1C);
        check("repeat_break_col", keyboard_COL, 8'hFF);
        check("repeat_events", ev_cnt - ev0, 3);

        // Bad frames are dropped silently
        ev0 = ev_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        check("bad_event", ev_cnt - ev0, 0);
        check("bad_col", keyboard_COL, 8'hFF);
        press(1'b0, 8'h5A);
        set_row(8'hFE);
        check("after_bad_col", keyboard_COL, 8'hFD);
        release_key(1'b0, 8'h5A);

        // Unmapped BAT byte clears a pending E0 and produces nothing
        ev0 = ev_cnt;
        send_byte(8'hE0);
        send_byte(8'hAA);
        check("bat_event", ev_cnt - ev0, 0);
        send_byte(8'h1C);
        set_row(8'hFD);
        check("ext_cleared_col", keyboard_COL, 8'hFB);
        release_key(1'b0, 8'h1C);

        // Timeout drops a partial frame
        ev0 = ev_cnt;
        send_frame(8'h29, 1'b0, 1'b1, 5);
        repeat (TO + 10) @(negedge dot_clk);
        send_byte(8'h29);
        set_row(8'h7F);
        check("timeout_col", keyboard_COL, 8'hEF);
        check("timeout_event", ev_cnt - ev0, 1);
        set_row(8'hFD);
        check("timeout_no_corrupt", keyboard_COL, 8'hFF);
        release_key(1'b0, 8'h29);

        // RESTORE
        press(1'b1, 8'h7D);
        check("restore_make", restore, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("restore_kept", restore, 1'b1);
        set_row(8'hFD);
        check("f0_1c_noop_col", keyboard_COL, 8'hFF);
        press(1'b0, 8'h66);
        set_row(8'hFC);
        check("pre_reset_col", keyboard_COL, 8'hFE);

        // Reset in the middle of a frame
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        do_reset();
        check("midreset_restore", restore, 1'b0);
        check("midreset_col", keyboard_COL, 8'hFF);
        check("midreset_event", key_event, 1'b0);
        repeat (4) @(negedge dot_clk);
        check("midreset_matrix", keyboard_COL, 8'hFF);
        ev0 = ev_cnt;
        send_byte(8'h1C);
        check("post_reset_col", keyboard_COL, 8'hFB);
        check("post_reset_event", ev_cnt - ev0, 1);

        // RESTORE break
        press(1'b1, 8'h7D);
        check("restore_make2", restore, 1'b1);
        release_key(1'b1, 8'h7D);
        check("restore_break", restore, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_c64_keyboard.md
Name: ps2_c64_keyboard

Overview:
- Upstream stage of the C64 keyboard connector.
- Receives PS/2 scancodes and maintains a 64-key C64 matrix image.
- Answers CIA1 row-select (keyboard_ROW, active-low) with active-low column sense on keyboard_COL.
- Also drives a RESTORE level that the top level ORs into the NMI path.

Parameters:
- TIMEOUT_CYCLES, 16384: dot_clk cycles without a PS/2 falling edge before an in-progress frame is aborted.
- SYNC_STAGES, 2: synchroniser depth for ps2_clk and ps2_data; minimum 2.

Ports:
- dot_clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  asynchronous PS/2 clock from the device.
- ps2_data  input  1  asynchronous PS/2 data from the device.
- keyboard_ROW  input  8  CIA1 port A row select; bit r low selects row r.
- keyboard_COL  output  8  column sense; bit c low when any selected row has key (r,c) down.
- restore  output  1  high while the RESTORE key is held.
- key_event  output  1  one-cycle pulse per accepted make or break code.

Behaviour:
- Reset: one dot_clk edge with reset high clears all state.
  - key_down matrix = 0, receive FSM = IDLE, ext/brk flags = 0.
  - keyboard_COL = 8'hFF, restore = 0, key_event = 0.
  - Reset overrides every other event in the same cycle, including a mid-frame reset: the partial frame is discarded.
- Input sync and edge detect:
  - ps2_clk and ps2_data pass through SYNC_STAGES flip-flops.
  - A falling edge is synced clk previous = 1 and current = 0. Data is sampled on that same cycle.
- Receive FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data = 0 (start bit), go to DATA and clear bit count. A start bit of 1 is ignored; stay in IDLE.
  - DATA: shift 8 bits LSB first; after bit 7, go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: stop bit = 1 and odd parity over data+parity is correct, so the byte is accepted. Otherwise discard silently. Return to IDLE either way.
  - Timeout counter resets on every falling edge and counts while not IDLE. Reaching TIMEOUT_CYCLES forces IDLE and discards the partial byte.
- Byte handling, acted on the cycle after acceptance:
  - 8'hE0 sets ext.
  - 8'hF0 sets brk.
  - Any other byte is looked up in the keymap with {ext, byte}, then both flags clear.
  - Mapped byte: key_down[row*8+col] = ~brk, and key_event pulses for 1 cycle.
  - Unmapped byte (including E1 and 8'hAA BAT): no matrix change, no key_event, flags still clear.
  - Typematic repeats of a make code are idempotent.
- Keymap: combinational; outputs valid, row[2:0], col[2:0], is_restore. Required entries:
  - 1C (A) -> row1,col2
  - 12 (LShift) -> row1,col7
  - 59 (RShift) -> row6,col4
  - 5A (Return) -> row0,col1
  - 29 (Space) -> row7,col4
  - 76 (Esc, RUN/STOP) -> row7,col7
  - 66 (Backspace, DEL) -> row0,col0
  - E0+7D (PgUp) -> is_restore
  - The remaining standard C64 keys map per the team keymap table.
- RESTORE: a restore make sets the restore register, a break clears it. It is not part of the 64-bit matrix.
- Column output:
  - Registered: keyboard_COL[c] <= ~OR over r of (key_down[r*8+c] & ~keyboard_ROW[r]).
  - Latency is 1 dot_clk from a keyboard_ROW change or a matrix update.
  - keyboard_ROW = 8'hFF yields 8'hFF.
  - Multiple selected rows OR together.
  - No ghosting emulation.
- Out of scope: host-to-device PS/2 transmission. The block never drives ps2_clk or ps2_data.

Decomposition:
- Shared package ps2_c64_pkg:
  - Scancode constants SC_EXT = 8'hE0 and SC_BRK = 8'hF0.
  - Receive FSM state encoding.
  - Matrix index function idx(row,col) = row*8+col.
- Sub-module ps2_c64_keymap: the combinational {ext, code} -> {valid, row, col, is_restore} lookup, kept separate so the table can be edited and tested alone.

Test Plan:
- Reset then idle: with keyboard_ROW = 8'hFE, keyboard_COL = 8'hFF and restore = 0.
- Frame 1C (good parity), then keyboard_ROW = 8'hFD: key_event pulses once and keyboard_COL = 8'hFB one cycle later. Then F0,1C -> keyboard_COL returns to 8'hFF and key_event pulses again.
- Chord: press 12 and 29, then keyboard_ROW = 8'h7D (rows 1 and 7) -> keyboard_COL = 8'h6F. keyboard_ROW = 8'hFD -> 8'h7F.
- Bad frame: send 1C with wrong parity, then 1C with stop bit = 0 -> no key_event and the matrix is unchanged. A following good 5A with keyboard_ROW = 8'hFE -> keyboard_COL = 8'hFD.
- Timeout: send start + 4 bits, pause for TIMEOUT_CYCLES+10 cycles, then send a full 29 -> Space registered (row7, col4), no corruption.
- RESTORE and reset: E0,7D -> restore = 1; F0 alone then 1C -> row1,col2 is released (no-op) and restore stays 1. Reset asserted mid-frame -> restore = 0, keyboard_COL = 8'hFF, and the next frame decodes normally.
